// File: rtl/param_serializer_if.sv
// rtl/param_serializer_if.sv - handshake bundle between TX controller and param_serializer
//
// Purpose : groups the parallel-word handshake, the shift tick and the serial
//           outputs of param_serializer into one interface.
// Signals : P_DATA   [DATA_W] parallel word to serialise          (master -> slave)
//           p_valid            P_DATA valid                        (master -> slave)
//           p_ready            slave can accept a word             (slave -> master)
//           ser_en             shift tick, one bit per high cycle  (master -> slave)
//           ser_data           registered serial bit               (slave -> master)
//           ser_done           one-cycle pulse on final bit        (slave -> master)
//           busy               word in flight                      (slave -> master)
//           par_en             parity request, captured with word  (master -> slave,
//                              only when SERIALIZER_PARITY_EN is defined)
// Modports: master (TX controller side), slave (serializer side).
// Macro   : SERIALIZER_PARITY_EN adds par_en.

interface param_serializer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] P_DATA;
   logic              p_valid;
   logic              p_ready;
   logic              ser_en;
   logic              ser_data;
   logic              ser_done;
   logic              busy;
`ifdef SERIALIZER_PARITY_EN
   logic              par_en;

   modport master (
      output P_DATA, p_valid, ser_en, par_en,
      input  p_ready, ser_data, ser_done, busy
   );

   modport slave (
      input  P_DATA, p_valid, ser_en, par_en,
      output p_ready, ser_data, ser_done, busy
   );
`else
   modport master (
      output P_DATA, p_valid, ser_en,
      input  p_ready, ser_data, ser_done, busy
   );

   modport slave (
      input  P_DATA, p_valid, ser_en,
      output p_ready, ser_data, ser_done, busy
   );
`endif
endinterface

// File: rtl/param_serializer.sv
// rtl/param_serializer.sv - parametrised parallel-to-serial shifter for the UART TX datapath
//
// Purpose : captures a DATA_W-bit word on a valid/ready handshake, then drives
//           it out one bit per ser_en tick, LSB- or MSB-first, with busy and a
//           one-cycle done pulse on the final bit.
// Params  : DATA_W    word width (>= 2)
//           MSB_FIRST 0 = bit 0 first, 1 = bit DATA_W-1 first
//           IDLE_LVL  ser_data level out of reset
//           PAR_ODD   parity sense (only with SERIALIZER_PARITY_EN)
// Ports   : CLK  clock
//           RST  synchronous, active-low reset
//           bus  param_serializer_if.slave (P_DATA, p_valid, p_ready, ser_en,
//                ser_data, ser_done, busy, and par_en with the macro)
// Macro   : SERIALIZER_PARITY_EN enables an optional trailing parity bit.

module param_serializer #(
   parameter int   DATA_W    = 8,
   parameter bit   MSB_FIRST = 1'b0,
   parameter logic IDLE_LVL  = 1'b1
`ifdef SERIALIZER_PARITY_EN
   ,
   parameter bit   PAR_ODD   = 1'b0
`endif
) (
   input  logic               CLK,
   input  logic               RST,
   param_serializer_if.slave  bus
);

`ifdef SERIALIZER_PARITY_EN
   // One extra count is needed to index the parity slot after the data bits.
   localparam int CNT_W = $clog2(DATA_W + 2);
`else
   localparam int CNT_W = $clog2(DATA_W + 1);
`endif
   localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] C_DATA_W = CNT_W'(DATA_W);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   w_shift_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_ser_data;
   logic                w_ser_data_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                w_head;
   logic [DATA_W-1:0]   w_shifted;
   logic                w_par_pend;
   logic                w_par_bit;

`ifdef SERIALIZER_PARITY_EN
   logic                r_par_en;
   logic                w_par_en_nxt;
   logic                r_par_bit;
   logic                w_par_bit_nxt;

   assign w_par_pend = r_par_en;
   assign w_par_bit  = r_par_bit;
`else
   assign w_par_pend = 1'b0;
   assign w_par_bit  = 1'b0;
`endif

   // Head bit and the register after shifting toward the head.
   assign w_head    = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
   assign w_shifted = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0}
                                : {1'b0, r_shift[DATA_W-1:1]};

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_ser_data <= IDLE_LVL;
         r_done     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ser_data <= w_ser_data_nxt;
         r_done     <= w_done_nxt;
`ifdef SERIALIZER_PARITY_EN
         r_par_en   <= w_par_en_nxt;
         r_par_bit  <= w_par_bit_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_cnt_nxt      = r_cnt;
      w_ser_data_nxt = r_ser_data;
      w_done_nxt     = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      w_par_en_nxt   = r_par_en;
      w_par_bit_nxt  = r_par_bit;
`endif

      case (r_state)
         S_IDLE: begin
            // ser_en is ignored here; ser_data keeps the last driven bit.
            if (bus.p_valid) begin
               w_shift_nxt = bus.P_DATA;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHIFT;
`ifdef SERIALIZER_PARITY_EN
               w_par_en_nxt  = bus.par_en;
               w_par_bit_nxt = (^bus.P_DATA) ^ PAR_ODD;
`endif
            end
         end

         S_SHIFT: begin
            if (bus.ser_en) begin
               if (w_par_pend && (r_cnt == C_DATA_W)) begin
                  // Parity slot follows the last data bit.
                  w_ser_data_nxt = w_par_bit;
                  w_cnt_nxt      = r_cnt + CNT_W'(1);
                  w_done_nxt     = 1'b1;
                  w_state_nxt    = S_IDLE;
               end else begin
                  w_ser_data_nxt = w_head;
                  w_shift_nxt    = w_shifted;
                  w_cnt_nxt      = r_cnt + CNT_W'(1);
                  // Leaving SHIFT on the final edge makes p_ready high in the
                  // done cycle, so the next word can be taken back-to-back.
                  if ((r_cnt == C_LAST) && !w_par_pend) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.p_ready  = (r_state == S_IDLE);
   assign bus.busy     = (r_state == S_SHIFT);
   assign bus.ser_data = r_ser_data;
   assign bus.ser_done = r_done;

endmodule
